// File: rtl/alu_checker.sv
// alu_checker: scores an 8-bit, 16-opcode ALU against a built-in golden model.
// The ALU result is compared one clk after its vector is accepted. Counts appear one clk after the compare.
// No backpressure: one vector per cycle is accepted while running. Extra vectors are dropped, never stalled.
//
// Build option: define ALU_CHECK_LOG_EN to add fail_a/fail_b/fail_got capture of the first failure.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start               one-cycle pulse that begins a run (honoured in IDLE or DONE)
//   vec_valid           A/B/ALU_Sel carry a vector for the ALU this cycle
//   A, B, ALU_Sel       operands/opcode driven to the ALU
//   ALU_Out             registered ALU result, valid one clk after its vector
//   busy, done          RUN|DRAIN, DONE
//   mismatch            one-cycle pulse per failed compare
//   pass_cnt, fail_cnt  saturating compare counts
//   first_fail_sel      opcode of the first failure in the run
module alu_checker #(
  parameter int NUM_VECTORS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       vec_valid,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  input  logic [7:0] ALU_Out,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [3:0] first_fail_sel
`ifdef ALU_CHECK_LOG_EN
  ,
  output logic [7:0] fail_a,
  output logic [7:0] fail_b,
  output logic [7:0] fail_got
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  state_t     state, state_nxt;
  logic [7:0] vec_cnt;
  logic       pending;
  logic [7:0] exp_res;
  logic [3:0] exp_sel;
  logic       fail_seen;
`ifdef ALU_CHECK_LOG_EN
  logic [7:0] exp_a;
  logic [7:0] exp_b;
`endif

  logic accept;
  logic restart;
  logic cmp_fail;
  logic cmp_pass;

  // 8-bit golden model; all arithmetic wraps, carries dropped.
  function automatic logic [7:0] golden(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    logic [7:0] res;
    res = 8'h00;
    case (sel)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a * b;
      4'd3:  res = (b == 8'h00) ? 8'hFF : a / b;
      4'd4:  res = a << 1;
      4'd5:  res = a >> 1;
      4'd6:  res = {a[6:0], a[7]};
      4'd7:  res = {a[0], a[7:1]};
      4'd8:  res = a & b;
      4'd9:  res = a | b;
      4'd10: res = a ^ b;
      4'd11: res = ~(a | b);
      4'd12: res = ~(a & b);
      4'd13: res = ~(a ^ b);
      4'd14: res = {7'd0, (a > b)};
      4'd15: res = {7'd0, (a == b)};
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  assign accept   = (state == RUN) && vec_valid;
  assign restart  = start && ((state == IDLE) || (state == DONE));
  assign cmp_fail = pending && (ALU_Out != exp_res);
  assign cmp_pass = pending && (ALU_Out == exp_res);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (accept && (vec_cnt == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_cnt        <= 8'h00;
      pending        <= 1'b0;
      exp_res        <= 8'h00;
      exp_sel        <= 4'h0;
      fail_seen      <= 1'b0;
      mismatch       <= 1'b0;
      pass_cnt       <= 8'h00;
      fail_cnt       <= 8'h00;
      first_fail_sel <= 4'h0;
`ifdef ALU_CHECK_LOG_EN
      exp_a          <= 8'h00;
      exp_b          <= 8'h00;
      fail_a         <= 8'h00;
      fail_b         <= 8'h00;
      fail_got       <= 8'h00;
`endif
    end else if (restart) begin
      vec_cnt        <= 8'h00;
      pending        <= 1'b0;
      fail_seen      <= 1'b0;
      mismatch       <= 1'b0;
      pass_cnt       <= 8'h00;
      fail_cnt       <= 8'h00;
      first_fail_sel <= 4'h0;
`ifdef ALU_CHECK_LOG_EN
      fail_a         <= 8'h00;
      fail_b         <= 8'h00;
      fail_got       <= 8'h00;
`endif
    end else begin
      mismatch <= cmp_fail;
      if (cmp_pass && (pass_cnt != 8'hFF)) pass_cnt <= pass_cnt + 8'd1;
      if (cmp_fail && (fail_cnt != 8'hFF)) fail_cnt <= fail_cnt + 8'd1;
      if (cmp_fail && !fail_seen) begin
        fail_seen      <= 1'b1;
        first_fail_sel <= exp_sel;
`ifdef ALU_CHECK_LOG_EN
        fail_a         <= exp_a;
        fail_b         <= exp_b;
        fail_got       <= ALU_Out;
`endif
      end
      // A vector accepted this cycle refills the slot being compared, so
      // back-to-back vectors stream at one per clk.
      pending <= accept;
      if (accept) begin
        exp_res <= golden(A, B, ALU_Sel);
        exp_sel <= ALU_Sel;
        vec_cnt <= vec_cnt + 8'd1;
`ifdef ALU_CHECK_LOG_EN
        exp_a   <= A;
        exp_b   <= B;
`endif
      end
    end
  end

endmodule
